// File: rtl/i2c_write_sequencer_if.sv
// i2c_write_sequencer_if: host request, datapath strobes and open-drain pad controls of the write sequencer
interface i2c_write_sequencer_if;
    logic       Start;
    logic [6:0] Addr;
    logic [3:0] Length;
    logic       DataBit;
    logic       SdaIn;
    logic       SclIn;
    logic       LoadData;
    logic       BitShift;
    logic       ByteAdvance;
    logic       SclOe;
    logic       SdaOe;
    logic       Busy;
    logic       Done;
    logic       Nack;
    modport master (
        input  Start, Addr, Length, DataBit, SdaIn, SclIn,
        output LoadData, BitShift, ByteAdvance, SclOe, SdaOe, Busy, Done, Nack
    );
    modport slave (
        output Start, Addr, Length, DataBit, SdaIn, SclIn,
        input  LoadData, BitShift, ByteAdvance, SclOe, SdaOe, Busy, Done, Nack
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: one I2C write (START, addr+W, 0..LEN_MAX bytes with ACK checks, STOP); I2C_CLOCK_STRETCH_EN adds SCL stretching
module i2c_write_sequencer #(
    parameter int DIV     = 125,
    parameter int LEN_MAX = 8
) (
    input logic                   Clock,
    input logic                   reset,
    i2c_write_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP} state_t;
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DMAX = CW'(DIV - 1);
    localparam logic [3:0] LMAX = 4'(LEN_MAX);
    state_t state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] byte_q, byte_d, len_q, len_d;
    logic [7:0] addr_q, addr_d;
    logic ack_q, ack_d, nack_q, nack_d, busy_q, busy_d, done_q, done_d;
    logic load_q, load_d, shift_q, shift_d, adv_q, adv_d, scl_q, scl_d, sda_q, sda_d;
    logic hold, tick, bit_end, sample, on_bus;
`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = state_q != IDLE && phase_q == 2'd2 && !bus.SclIn;
`else
    logic unused_scl;
    assign unused_scl = bus.SclIn;
    assign hold = 1'b0;
`endif
    assign tick = div_q == DMAX && !hold;
    assign bit_end = tick && phase_q == 2'd3;
    assign sample = tick && phase_q == 2'd2 && (state_q == AACK || state_q == DACK);
    always_comb begin
        state_d = state_q;
        div_d = (tick || hold) ? '0 : div_q + 1'b1;
        phase_d = tick ? phase_q + 2'd1 : phase_q;
        bit_d = bit_q;
        byte_d = byte_q;
        len_d = len_q;
        addr_d = addr_q;
        ack_d = sample ? !bus.SdaIn : ack_q;
        nack_d = nack_q || (sample && bus.SdaIn);
        busy_d = busy_q;
        done_d = 1'b0;
        load_d = 1'b0;
        shift_d = 1'b0;
        adv_d = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                phase_d = '0;
                if (bus.Start && !done_q) begin
                    state_d = START;
                    len_d = bus.Length > LMAX ? LMAX : bus.Length;
                    addr_d = {bus.Addr, 1'b0};
                    byte_d = '0;
                    bit_d = 3'd7;
                    nack_d = 1'b0;
                    busy_d = 1'b1;
                    load_d = 1'b1;
                end
            end
            START: state_d = bit_end ? ADDR : START;
            ADDR: if (bit_end) begin
                addr_d = addr_q << 1;
                bit_d = bit_q - 3'd1;
                state_d = bit_q == 3'd0 ? AACK : ADDR;
            end
            AACK: if (bit_end) state_d = (ack_q && len_q != 4'd0) ? DATA : STOP;
            DATA: if (bit_end) begin
                bit_d = bit_q - 3'd1;
                state_d = bit_q == 3'd0 ? DACK : DATA;
                byte_d = bit_q == 3'd0 ? byte_q + 4'd1 : byte_q;
                shift_d = bit_q != 3'd0;
            end
            DACK: if (bit_end) begin
                adv_d = ack_q && byte_q != len_q;
                state_d = (ack_q && byte_q != len_q) ? DATA : STOP;
            end
            STOP: if (bit_end) begin
                state_d = IDLE;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        on_bus = state_d == ADDR || state_d == AACK || state_d == DATA || state_d == DACK;
        scl_d = on_bus ? phase_d < 2'd2 : state_d == STOP && phase_d == 2'd0;
        // the datapath shifts one cycle into ph0, so DATA keeps tracking DataBit while SCL is low
        sda_d = state_d == START ? phase_d >= 2'd2 :
                state_d == ADDR  ? !addr_d[7] :
                state_d == DATA  ? (phase_d < 2'd2 ? !bus.DataBit : sda_q) :
                state_d == STOP && phase_d < 2'd2;
    end
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            {div_q, phase_q, bit_q, byte_q, len_q, addr_q} <= '0;
            {ack_q, nack_q, busy_q, done_q, load_q, shift_q, adv_q, scl_q, sda_q} <= '0;
        end else begin
            state_q <= state_d;
            {div_q, phase_q, bit_q, byte_q, len_q, addr_q} <= {div_d, phase_d, bit_d, byte_d, len_d, addr_d};
            {ack_q, nack_q, busy_q, done_q, load_q, shift_q, adv_q, scl_q, sda_q} <=
                {ack_d, nack_d, busy_d, done_d, load_d, shift_d, adv_d, scl_d, sda_d};
        end
    end
    assign bus.LoadData = load_q;
    assign bus.BitShift = shift_q;
    assign bus.ByteAdvance = adv_q;
    assign bus.SclOe = scl_q;
    assign bus.SdaOe = sda_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Nack = nack_q;
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb_i2c_write_sequencer: directed bench with datapath shift-register model and I2C slave/bus monitor
module tb_i2c_write_sequencer;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam int STRETCH = 20;
`else
    localparam int STRETCH = 0;
`endif
    logic Clock = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 Clock = ~Clock;
    i2c_write_sequencer_if bus();
    i2c_write_sequencer #(.DIV(4), .LEN_MAX(8)) dut (.Clock(Clock), .reset(reset), .bus(bus));
    logic [7:0] mem [0:7];
    logic [2:0] m_byte = 3'd0;
    logic [2:0] m_bit = 3'd7;
    assign bus.DataBit = mem[m_byte][m_bit];
    always @(posedge Clock) begin
        if (bus.LoadData) begin
            m_byte <= 3'd0;
            m_bit <= 3'd7;
        end else if (bus.BitShift) m_bit <= m_bit - 3'd1;
        else if (bus.ByteAdvance) begin
            m_byte <= m_byte + 3'd1;
            m_bit <= 3'd7;
        end
    end
    int n_load = 0, n_shift = 0, n_adv = 0, n_done = 0;
    always @(posedge Clock) begin
        n_load <= n_load + int'(bus.LoadData);
        n_shift <= n_shift + int'(bus.BitShift);
        n_adv <= n_adv + int'(bus.ByteAdvance);
        n_done <= n_done + int'(bus.Done);
    end
    logic pull = 1'b0;
    logic scl_l, sda_l;
    logic scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] sr = 8'h00;
    logic [7:0] rx [0:15];
    int nbit = 0, nbyte = 0, nack_at = -1;
    assign scl_l = ~bus.SclOe;
    assign sda_l = ~(bus.SdaOe | pull);
    assign bus.SdaIn = sda_l;
    always @(posedge Clock) begin
        scl_p <= scl_l;
        sda_p <= sda_l;
        if (reset) pull <= 1'b0;
        else if (scl_l && scl_p && sda_p && !sda_l) begin
            nbit <= 0;
            nbyte <= 0;
        end else if (scl_l && !scl_p) begin
            if (nbit < 8) sr <= {sr[6:0], sda_l};
            if (nbit == 7 && nbyte < 16) rx[nbyte] <= {sr[6:0], sda_l};
            nbit <= nbit + 1;
        end else if (!scl_l && scl_p) begin
            if (nbit == 8) pull <= (nbyte != nack_at);
            else if (nbit == 9) begin
                pull <= 1'b0;
                nbit <= 0;
                nbyte <= nbyte + 1;
            end
        end
    end
    task automatic kick(input logic [6:0] a, input logic [3:0] l);
        @(posedge Clock); #1;
        bus.Start = 1'b1; bus.Addr = a; bus.Length = l;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
    endtask
    task automatic wait_done(output int k);
        k = 0;
        while (k < 3000 && !bus.Done) begin
            @(posedge Clock); #1;
            k++;
        end
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        checks++; if ({bus.SclOe, bus.SdaOe, bus.Busy, bus.Done, bus.Nack, bus.LoadData, bus.BitShift, bus.ByteAdvance} !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b exp=00000000", {bus.SclOe, bus.SdaOe, bus.Busy, bus.Done, bus.Nack, bus.LoadData, bus.BitShift, bus.ByteAdvance}); end
        reset = 1'b0;
        repeat (2) @(posedge Clock);
    endtask
    task automatic test_write;
        int k, l0, s0, a0;
        mem[0] = 8'hA5; mem[1] = 8'h3C; nack_at = -1;
        l0 = n_load; s0 = n_shift; a0 = n_adv;
        kick(7'h50, 4'd2);
        checks++; if ({bus.Busy, bus.LoadData} !== 2'b11) begin errors++; $display("FAIL write_accept got=%b exp=11", {bus.Busy, bus.LoadData}); end
        wait_done(k);
        checks++; if (k !== 464) begin errors++; $display("FAIL write_latency got=%0d exp=464", k); end
        checks++; if ({rx[0], rx[1], rx[2]} !== 24'hA0A53C) begin errors++; $display("FAIL write_bytes got=%h exp=a0a53c", {rx[0], rx[1], rx[2]}); end
        checks++; if (nbyte !== 3) begin errors++; $display("FAIL write_nbytes got=%0d exp=3", nbyte); end
        checks++; if (n_load - l0 !== 1) begin errors++; $display("FAIL write_load got=%0d exp=1", n_load - l0); end
        checks++; if (n_shift - s0 !== 14) begin errors++; $display("FAIL write_shift got=%0d exp=14", n_shift - s0); end
        checks++; if (n_adv - a0 !== 1) begin errors++; $display("FAIL write_adv got=%0d exp=1", n_adv - a0); end
        checks++; if ({bus.Nack, bus.Busy} !== 2'b00) begin errors++; $display("FAIL write_nack_busy got=%b exp=00", {bus.Nack, bus.Busy}); end
        @(posedge Clock); #1;
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL write_done_pulse got=%b exp=0", bus.Done); end
    endtask
    task automatic test_zero_len;
        int k, s0, a0;
        nack_at = -1;
        s0 = n_shift; a0 = n_adv;
        kick(7'h22, 4'd0);
        wait_done(k);
        checks++; if (k !== 176) begin errors++; $display("FAIL zero_latency got=%0d exp=176", k); end
        checks++; if (rx[0] !== 8'h44 || nbyte !== 1) begin errors++; $display("FAIL zero_addr got=%h/%0d exp=44/1", rx[0], nbyte); end
        checks++; if (n_shift - s0 !== 0 || n_adv - a0 !== 0) begin errors++; $display("FAIL zero_strobes got=%0d/%0d exp=0/0", n_shift - s0, n_adv - a0); end
    endtask
    task automatic test_nack;
        int k, a0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; nack_at = 2;
        a0 = n_adv;
        kick(7'h2A, 4'd3);
        repeat (443) @(posedge Clock);
        #1;
        checks++; if (bus.Nack !== 1'b0) begin errors++; $display("FAIL nack_before got=%b exp=0", bus.Nack); end
        @(posedge Clock); #1;
        checks++; if (bus.Nack !== 1'b1) begin errors++; $display("FAIL nack_at_tick got=%b exp=1", bus.Nack); end
        wait_done(k);
        checks++; if (444 + k !== 464) begin errors++; $display("FAIL nack_latency got=%0d exp=464", 444 + k); end
        checks++; if (nbyte !== 3 || rx[2] !== 8'h22) begin errors++; $display("FAIL nack_bytes got=%0d/%h exp=3/22", nbyte, rx[2]); end
        checks++; if (n_adv - a0 !== 1) begin errors++; $display("FAIL nack_adv got=%0d exp=1", n_adv - a0); end
        repeat (10) @(posedge Clock);
        #1;
        checks++; if (bus.Nack !== 1'b1) begin errors++; $display("FAIL nack_sticky got=%b exp=1", bus.Nack); end
        nack_at = -1;
    endtask
    task automatic test_back_to_back;
        int k, l0;
        l0 = n_load;
        kick(7'h22, 4'd0);
        checks++; if (bus.Nack !== 1'b0) begin errors++; $display("FAIL b2b_nack_clear got=%b exp=0", bus.Nack); end
        repeat (50) @(posedge Clock);
        #1;
        bus.Start = 1'b1; bus.Addr = 7'h7F; bus.Length = 4'd5;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        wait_done(k);
        checks++; if (51 + k !== 176) begin errors++; $display("FAIL b2b_busy_latency got=%0d exp=176", 51 + k); end
        checks++; if (rx[0] !== 8'h44 || nbyte !== 1) begin errors++; $display("FAIL b2b_busy_addr got=%h/%0d exp=44/1", rx[0], nbyte); end
        bus.Start = 1'b1; bus.Addr = 7'h33; bus.Length = 4'd0;
        @(posedge Clock); #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle got=%b exp=0", bus.Busy); end
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL b2b_next_accept got=%b exp=1", bus.Busy); end
        wait_done(k);
        checks++; if (k !== 176 || rx[0] !== 8'h66) begin errors++; $display("FAIL b2b_second got=%0d/%h exp=176/66", k, rx[0]); end
        checks++; if (n_load - l0 !== 2) begin errors++; $display("FAIL b2b_loads got=%0d exp=2", n_load - l0); end
    endtask
    task automatic test_mid_reset;
        int k, d0;
        mem[0] = 8'hA5; mem[1] = 8'h3C; nack_at = -1;
        kick(7'h50, 4'd2);
        repeat (214) @(posedge Clock);
        #1;
        checks++; if ({bus.SclOe, bus.Busy} !== 2'b11) begin errors++; $display("FAIL midrst_pre got=%b exp=11", {bus.SclOe, bus.Busy}); end
        reset = 1'b1;
        @(posedge Clock); #1;
        checks++; if ({bus.SclOe, bus.SdaOe, bus.Busy, bus.Done} !== 4'b0000) begin errors++; $display("FAIL midrst_release got=%b exp=0000", {bus.SclOe, bus.SdaOe, bus.Busy, bus.Done}); end
        reset = 1'b0;
        d0 = n_done;
        repeat (40) @(posedge Clock);
        #1;
        checks++; if (n_done !== d0 || bus.SclOe !== 1'b0) begin errors++; $display("FAIL midrst_quiet got=%0d/%b exp=%0d/0", n_done, bus.SclOe, d0); end
        kick(7'h11, 4'd1);
        wait_done(k);
        checks++; if (k !== 320) begin errors++; $display("FAIL midrst_latency got=%0d exp=320", k); end
        checks++; if ({rx[0], rx[1]} !== 16'h22A5 || nbyte !== 2) begin errors++; $display("FAIL midrst_bytes got=%h/%0d exp=22a5/2", {rx[0], rx[1]}, nbyte); end
    endtask
    task automatic test_clamp;
        int k, s0, a0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        nack_at = -1;
        s0 = n_shift; a0 = n_adv;
        kick(7'h0F, 4'd12);
        wait_done(k);
        checks++; if (k !== 1328) begin errors++; $display("FAIL clamp_latency got=%0d exp=1328", k); end
        checks++; if (nbyte !== 9 || rx[1] !== 8'h10 || rx[8] !== 8'h17) begin errors++; $display("FAIL clamp_bytes got=%0d/%h/%h exp=9/10/17", nbyte, rx[1], rx[8]); end
        checks++; if (n_shift - s0 !== 56 || n_adv - a0 !== 7) begin errors++; $display("FAIL clamp_strobes got=%0d/%0d exp=56/7", n_shift - s0, n_adv - a0); end
    endtask
    task automatic test_stretch;
        int k;
        nack_at = -1;
        kick(7'h50, 4'd0);
        repeat (88) @(posedge Clock);
        #1;
        bus.SclIn = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
        bus.SclIn = 1'b1;
        wait_done(k);
        checks++; if (108 + k !== 176 + STRETCH) begin errors++; $display("FAIL stretch_latency got=%0d exp=%0d", 108 + k, 176 + STRETCH); end
        checks++; if (rx[0] !== 8'hA0 || bus.Nack !== 1'b0) begin errors++; $display("FAIL stretch_data got=%h/%b exp=a0/0", rx[0], bus.Nack); end
    endtask
    initial begin
        bus.Start = 1'b0; bus.Addr = 7'h00; bus.Length = 4'd0; bus.SclIn = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        test_reset;
        test_write;
        test_zero_len;
        test_nack;
        test_back_to_back;
        test_mid_reset;
        test_clamp;
        test_stretch;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
